// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting session controller.
//   session_state_t : controller FSM state encoding (IDLE/OPEN/TALLY/CLEAR)
//   MODE_*          : mode codes driven to the voting core
//   is_onehot()     : ballot validity check on a candidate vector
package vote_pkg;

  localparam int unsigned CAND_W  = 4;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned REJ_W   = 8;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_TALLY = 3'd2,
    ST_CLEAR = 3'd3
  } session_state_t;

  localparam logic [1:0] MODE_VOTE  = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  // True when exactly one candidate bit is set.
  function automatic logic is_onehot(input logic [CAND_W-1:0] v);
    return (v != '0) && ((v & (v - CAND_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : per-requester request vector
//   ptr         : highest-priority index for this cycle
//   enable      : when low, no grant is issued
//   grant       : one-hot grant
//   grant_valid : a grant was issued
module rr_arbiter #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid
);

  // Search ptr..WIDTH-1 first, then wrap to 0..ptr-1.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (enable && !grant_valid && req[i] && (i >= int'(ptr))) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (enable && !grant_valid && req[i] && (i < int'(ptr))) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Session controller and booth arbiter for the voting core.
//   clk, rst                 : clock, async active-high reset
//   booth_req/booth_choice   : per-booth level request and 4-bit candidate vector
//   booth_ack/booth_nack     : 1-cycle accept/reject response pulses
//   admin_open/close/clear   : session commands (clear > close > open)
//   mode_out                 : core mode for the current session state
//   vote_strobe/vote_onehot  : confirm pulse and candidate to the core
//   session_state            : FSM state encoding
//   accepted_cnt/rejected_cnt: saturating ballot statistics
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned CLEAR_CYC  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BOOTHS-1:0]        booth_req,
  input  logic [CAND_W*NUM_BOOTHS-1:0] booth_choice,
  output logic [NUM_BOOTHS-1:0]        booth_ack,
  output logic [NUM_BOOTHS-1:0]        booth_nack,
  input  logic                         admin_open,
  input  logic                         admin_close,
  input  logic                         admin_clear,
  output logic [1:0]                   mode_out,
  output logic                         vote_strobe,
  output logic [CAND_W-1:0]            vote_onehot,
  output logic [STATE_W-1:0]           session_state,
  output logic [ACC_W-1:0]             accepted_cnt,
  output logic [REJ_W-1:0]             rejected_cnt
);

  localparam int unsigned PTR_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int unsigned CLR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

  session_state_t          state;
  logic [CLR_W-1:0]        clr_cnt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [NUM_BOOTHS-1:0]   armed;
  logic                    grant_last;

  logic [NUM_BOOTHS-1:0]   eligible;
  logic                    arb_en;
  logic [NUM_BOOTHS-1:0]   gnt;
  logic                    gnt_valid;
  logic [PTR_W-1:0]        gnt_idx;
  logic [CAND_W-1:0]       gnt_choice;
  logic [PTR_W-1:0]        next_ptr;
  logic                    accept;

  assign session_state = state;

  // Only armed requesters compete; a grant blocks the next cycle so the
  // confirm strobe always has a low cycle between pulses. CLEAR holds requests.
  assign eligible = booth_req & armed;
  assign arb_en   = !grant_last && (state != ST_CLEAR);

  rr_arbiter #(.WIDTH(NUM_BOOTHS)) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .enable      (arb_en),
    .grant       (gnt),
    .grant_valid (gnt_valid)
  );

  // Granted booth index and its ballot.
  always_comb begin
    gnt_idx    = '0;
    gnt_choice = '0;
    for (int i = 0; i < int'(NUM_BOOTHS); i++) begin
      if (gnt[i]) begin
        gnt_idx    = PTR_W'(i);
        gnt_choice = booth_choice[CAND_W*i +: CAND_W];
      end
    end
  end

  assign next_ptr = (gnt_idx == PTR_W'(NUM_BOOTHS - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Old state decides; a concurrent clear forces a reject.
  assign accept = gnt_valid && (state == ST_OPEN) && !admin_clear && is_onehot(gnt_choice);

  // Session FSM, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      clr_cnt      <= '0;
      mode_out     <= MODE_IDLE;
      rr_ptr       <= '0;
      armed        <= '1;
      grant_last   <= 1'b0;
      booth_ack    <= '0;
      booth_nack   <= '0;
      vote_strobe  <= 1'b0;
      vote_onehot  <= '0;
      accepted_cnt <= '0;
      rejected_cnt <= '0;
    end else begin
      booth_ack   <= '0;
      booth_nack  <= '0;
      vote_strobe <= 1'b0;
      vote_onehot <= '0;
      grant_last  <= gnt_valid;
      // Disarm on own response; re-arm once the request is seen low.
      armed       <= ~gnt & (armed | ~booth_req);

      if (gnt_valid) begin
        rr_ptr <= next_ptr;
        if (accept) begin
          booth_ack   <= gnt;
          vote_strobe <= 1'b1;
          vote_onehot <= gnt_choice;
          if (accepted_cnt != '1) accepted_cnt <= accepted_cnt + ACC_W'(1);
        end else begin
          booth_nack <= gnt;
          if (rejected_cnt != '1) rejected_cnt <= rejected_cnt + REJ_W'(1);
        end
      end

      // Clear wins over everything, including this cycle's counter update.
      if (admin_clear) begin
        state        <= ST_CLEAR;
        mode_out     <= MODE_CLEAR;
        clr_cnt      <= '0;
        accepted_cnt <= '0;
        rejected_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (admin_open) begin
              state    <= ST_OPEN;
              mode_out <= MODE_VOTE;
            end
          end
          ST_OPEN: begin
            if (admin_close) begin
              state    <= ST_TALLY;
              mode_out <= MODE_COUNT;
            end
          end
          ST_TALLY: ;
          ST_CLEAR: begin
            if (clr_cnt == CLR_W'(CLEAR_CYC - 1)) begin
              state    <= ST_IDLE;
              mode_out <= MODE_IDLE;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          default: begin
            state    <= ST_IDLE;
            mode_out <= MODE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the session/arbitration rules.
module tb_vote_session_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned CC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB-1:0]     booth_req = '0;
  logic [4*NB-1:0]   booth_choice = '0;
  logic [NB-1:0]     booth_ack, booth_nack;
  logic              admin_open = 1'b0, admin_close = 1'b0, admin_clear = 1'b0;
  logic [1:0]        mode_out;
  logic              vote_strobe;
  logic [3:0]        vote_onehot;
  logic [2:0]        session_state;
  logic [15:0]       accepted_cnt;
  logic [7:0]        rejected_cnt;

  int nchecks = 0;
  int nerr    = 0;

  vote_session_ctrl #(.NUM_BOOTHS(NB), .CLEAR_CYC(CC)) dut (
    .clk           (clk),
    .rst           (rst),
    .booth_req     (booth_req),
    .booth_choice  (booth_choice),
    .booth_ack     (booth_ack),
    .booth_nack    (booth_nack),
    .admin_open    (admin_open),
    .admin_close   (admin_close),
    .admin_clear   (admin_clear),
    .mode_out      (mode_out),
    .vote_strobe   (vote_strobe),
    .vote_onehot   (vote_onehot),
    .session_state (session_state),
    .accepted_cnt  (accepted_cnt),
    .rejected_cnt  (rejected_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 open, 2 tally, 3 clear
  int          m_phase, m_clr_left, m_ptr, m_acc, m_rej;
  bit          m_busy;
  bit [NB-1:0] m_armed;
  logic [NB-1:0] e_ack, e_nack;
  logic          e_strobe;
  logic [3:0]    e_onehot;
  logic [1:0]    mode_tab [4] = '{2'b11, 2'b00, 2'b01, 2'b10};

  always @(posedge clk or posedge rst) begin
    int g;
    logic [3:0] ch;
    if (rst) begin
      m_phase = 0; m_clr_left = 0; m_ptr = 0; m_acc = 0; m_rej = 0;
      m_busy = 1'b0; m_armed = '1;
      e_ack = '0; e_nack = '0; e_strobe = 1'b0; e_onehot = '0;
    end else begin
      e_ack = '0; e_nack = '0; e_strobe = 1'b0; e_onehot = '0;
      g = -1;
      if (!m_busy && m_phase != 3) begin
        for (int k = 0; k < int'(NB); k++) begin
          int b;
          b = (m_ptr + k) % int'(NB);
          if (g < 0 && booth_req[b] && m_armed[b]) g = b;
        end
      end
      for (int b = 0; b < int'(NB); b++) begin
        if (b == g) m_armed[b] = 1'b0;
        else if (!booth_req[b]) m_armed[b] = 1'b1;
      end
      m_busy = (g >= 0);
      if (g >= 0) begin
        m_ptr = (g + 1) % int'(NB);
        ch = booth_choice[4*g +: 4];
        if (m_phase == 1 && !admin_clear && $countones(ch) == 1) begin
          e_ack[g] = 1'b1; e_strobe = 1'b1; e_onehot = ch;
          if (m_acc < 65535) m_acc = m_acc + 1;
        end else begin
          e_nack[g] = 1'b1;
          if (m_rej < 255) m_rej = m_rej + 1;
        end
      end
      if (admin_clear) begin
        m_phase = 3; m_clr_left = int'(CC); m_acc = 0; m_rej = 0;
      end else if (m_phase == 0 && admin_open) m_phase = 1;
      else if (m_phase == 1 && admin_close) m_phase = 2;
      else if (m_phase == 3) begin
        m_clr_left = m_clr_left - 1;
        if (m_clr_left == 0) m_phase = 0;
      end
    end
  end

  // ---------------- checking ----------------
  logic prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("ack", 32'(booth_ack), 32'(e_ack));
    chk("nack", 32'(booth_nack), 32'(e_nack));
    chk("strobe", 32'(vote_strobe), 32'(e_strobe));
    if (e_strobe) chk("onehot", 32'(vote_onehot), 32'(e_onehot));
    chk("mode", 32'(mode_out), 32'(mode_tab[m_phase]));
    chk("state", 32'(session_state), 32'(m_phase));
    chk("acc_cnt", 32'(accepted_cnt), 32'(m_acc));
    chk("rej_cnt", 32'(rejected_cnt), 32'(m_rej));
    chk("strobe_gap", 32'(prev_strobe & vote_strobe), 32'd0);
    prev_strobe = vote_strobe;
  endtask

  // Advance to the next falling edge and check outputs of the last rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) model_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    booth_req = '0; booth_choice = '0;
    admin_open = 1'b0; admin_close = 1'b0; admin_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_strobe = 1'b0;
  endtask

  task automatic open_session();
    admin_open = 1'b1;
    step();
    admin_open = 1'b0;
  endtask

  function automatic logic [3:0] rand_choice();
    logic [3:0] one;
    one = 4'b0001;
    if ($urandom_range(0, 1) == 0) return one << $urandom_range(0, 3);
    return 4'($urandom);
  endfunction

  initial begin
    int ack_cyc [NB];
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_mode", 32'(mode_out), 32'h3);
    chk("rst_state", 32'(session_state), 32'h0);
    chk("rst_strobe", 32'(vote_strobe), 32'h0);
    chk("rst_ack", 32'(booth_ack | booth_nack), 32'h0);
    chk("rst_cnt", 32'({accepted_cnt, rejected_cnt}), 32'h0);

    // Basic accept: booth 2 votes 0100
    open_session();
    booth_req[2] = 1'b1; booth_choice[11:8] = 4'b0100;
    step();
    chk("basic_strobe", 32'(vote_strobe), 32'h1);
    chk("basic_onehot", 32'(vote_onehot), 32'h4);
    chk("basic_ack", 32'(booth_ack), 32'h4);
    chk("basic_acc", 32'(accepted_cnt), 32'h1);
    booth_req = '0;
    step();

    // Simultaneous requests: acks 0,1,2,3 on cycles 1,3,5,7
    do_reset();
    open_session();
    booth_req = '1; booth_choice = 16'b1000_0100_0010_0001;
    for (int i = 0; i < int'(NB); i++) ack_cyc[i] = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      for (int i = 0; i < int'(NB); i++)
        if (booth_ack[i]) begin ack_cyc[i] = c; booth_req[i] = 1'b0; end
    end
    for (int i = 0; i < int'(NB); i++) chk("simul_ack_cycle", 32'(ack_cyc[i]), 32'(2*i + 1));
    chk("simul_acc", 32'(accepted_cnt), 32'h4);

    // Invalid ballot
    do_reset();
    open_session();
    booth_req[1] = 1'b1; booth_choice[7:4] = 4'b0110;
    step();
    chk("inval_nack", 32'(booth_nack), 32'h2);
    chk("inval_strobe", 32'(vote_strobe), 32'h0);
    chk("inval_rej", 32'(rejected_cnt), 32'h1);
    booth_req = '0;
    step();

    // Re-arm: held request gets one ack only until it drops
    do_reset();
    open_session();
    booth_req[0] = 1'b1; booth_choice[3:0] = 4'b0010;
    step();
    chk("rearm_first", 32'(booth_ack), 32'h1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rearm_hold", 32'(booth_ack | booth_nack), 32'h0);
    end
    booth_req[0] = 1'b0;
    step();
    booth_req[0] = 1'b1;
    step();
    chk("rearm_second", 32'(booth_ack), 32'h1);
    chk("rearm_acc", 32'(accepted_cnt), 32'h2);
    booth_req = '0;
    step();

    // Session sequence and TALLY nack
    do_reset();
    chk("seq_mode0", 32'(mode_out), 32'h3);
    admin_open = 1'b1; step(); admin_open = 1'b0;
    chk("seq_mode1", 32'(mode_out), 32'h0);
    admin_close = 1'b1; step(); admin_close = 1'b0;
    chk("seq_mode2", 32'(mode_out), 32'h1);
    booth_req[3] = 1'b1; booth_choice[15:12] = 4'b0001;
    step();
    chk("tally_nack", 32'(booth_nack), 32'h8);
    chk("tally_rej", 32'(rejected_cnt), 32'h1);
    booth_req = '0;
    admin_clear = 1'b1; step(); admin_clear = 1'b0;
    chk("seq_mode3", 32'(mode_out), 32'h2);
    chk("seq_cnt_clr", 32'({accepted_cnt, rejected_cnt}), 32'h0);
    step();
    chk("seq_mode4", 32'(mode_out), 32'h2);
    step();
    chk("seq_mode5", 32'(mode_out), 32'h3);

    // Reject-counter saturation from IDLE traffic
    do_reset();
    for (int c = 0; c < 1400; c++) begin
      booth_req = 4'($urandom);
      step();
    end
    chk("rej_saturate", 32'(rejected_cnt), 32'hFF);
    booth_req = '0;
    step();

    // Randomized sessions
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      admin_open  = ($urandom_range(0, 5) == 0);
      admin_close = ($urandom_range(0, 15) == 0);
      admin_clear = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < int'(NB); i++) begin
        if (booth_req[i]) begin
          if (booth_ack[i] || booth_nack[i]) booth_req[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 2) == 0) begin
          booth_req[i] = 1'b1;
          booth_choice[4*i +: 4] = rand_choice();
        end
      end
      step();
    end
    admin_open = 1'b0; admin_close = 1'b0; admin_clear = 1'b0;

    // Asynchronous reset in the middle of a response
    do_reset();
    open_session();
    booth_req[1] = 1'b1; booth_choice[7:4] = 4'b0010;
    step();
    chk("pre_rst_strobe", 32'(vote_strobe), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", 32'(mode_out), 32'h3);
    chk("arst_state", 32'(session_state), 32'h0);
    chk("arst_strobe", 32'(vote_strobe), 32'h0);
    chk("arst_onehot", 32'(vote_onehot), 32'h0);
    chk("arst_resp", 32'(booth_ack | booth_nack), 32'h0);
    chk("arst_cnt", 32'({accepted_cnt, rejected_cnt}), 32'h0);
    booth_req = '0;
    @(negedge clk);
    rst = 1'b0;
    prev_strobe = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
